// File: rtl/rv_mem_arb.sv
// Single-port memory arbiter for the RV32I core: one bus transaction at a time between
// instruction fetch and data access, D-over-I priority with alternation, and a bus watchdog.
module rv_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_arb_if_req,
    input  logic [31:0] i_arb_if_addr,
    output logic        o_arb_if_valid,
    output logic [31:0] o_arb_if_rdata,
    input  logic        i_arb_d_req,
    input  logic        i_arb_d_we,
    input  logic [2:0]  i_arb_d_bytectrl,
    input  logic [31:0] i_arb_d_addr,
    input  logic [31:0] i_arb_d_wdata,
    output logic        o_arb_d_valid,
    output logic [31:0] o_arb_d_rdata,
    output logic        o_arb_mem_req,
    output logic        o_arb_mem_we,
    output logic [2:0]  o_arb_mem_bytectrl,
    output logic [31:0] o_arb_mem_addr,
    output logic [31:0] o_arb_mem_wdata,
    input  logic        i_arb_mem_ack,
    input  logic [31:0] i_arb_mem_rdata,
    output logic        o_arb_stall,
    output logic        o_arb_err
);
    localparam logic [2:0]  DMEM_BYTECTRL_WORD = 3'b010;
    localparam logic [15:0] WDOG_LAST          = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] { IDLE, BUSY_I, BUSY_D } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] wdog_q, wdog_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_bytectrl_q, mem_bytectrl_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;

    logic busy, ack, abort, if_done, d_done, if_elig, d_elig, grant_window, grant_i, grant_d;

    always_comb begin
        busy         = (state_q != IDLE);
        // mem_req_q is high exactly while busy, so a stale ack is filtered here
        ack          = busy && i_arb_mem_ack;
        abort        = busy && !i_arb_mem_ack && (wdog_q == WDOG_LAST);
        if_done      = (state_q == BUSY_I) && (ack || abort);
        d_done       = (state_q == BUSY_D) && (ack || abort);
        if_elig      = i_arb_if_req && !if_valid_q && !if_done;
        d_elig       = i_arb_d_req && !d_valid_q && !d_done;
        grant_window = (state_q == IDLE) || ack;
        grant_i      = grant_window && if_elig && (last_d_q || !d_elig);
        grant_d      = grant_window && d_elig && !grant_i;
    end

    always_comb begin
        // NOTE: every signal gets its hold/default value first so no path infers a latch.
        state_d        = state_q;
        last_d_d       = last_d_q;
        wdog_d         = wdog_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_bytectrl_d = mem_bytectrl_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if_valid_d     = 1'b0;
        d_valid_d      = 1'b0;
        if_rdata_d     = if_rdata_q;
        d_rdata_d      = d_rdata_q;
        err_d          = 1'b0;

        if (busy && !ack && !abort) begin
            wdog_d = wdog_q + 16'd1;
        end

        if (abort) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            if (state_q == BUSY_I) begin
                if_valid_d = 1'b1;
                if_rdata_d = 32'h0;
            end else begin
                d_valid_d = 1'b1;
                d_rdata_d = 32'h0;
            end
        end

        if (ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (state_q == BUSY_I) begin
                if_valid_d = 1'b1;
                if_rdata_d = i_arb_mem_rdata;
            end else begin
                d_valid_d = 1'b1;
                if (!mem_we_q) begin
                    d_rdata_d = i_arb_mem_rdata;
                end
            end
        end

        // A grant here overrides the return to IDLE, giving back-to-back transfers
        if (grant_i) begin
            state_d        = BUSY_I;
            last_d_d       = 1'b0;
            wdog_d         = 16'd0;
            mem_req_d      = 1'b1;
            mem_we_d       = 1'b0;
            mem_bytectrl_d = DMEM_BYTECTRL_WORD;
            mem_addr_d     = i_arb_if_addr;
            mem_wdata_d    = 32'h0;
        end else if (grant_d) begin
            state_d        = BUSY_D;
            last_d_d       = 1'b1;
            wdog_d         = 16'd0;
            mem_req_d      = 1'b1;
            mem_we_d       = i_arb_d_we;
            mem_bytectrl_d = i_arb_d_bytectrl;
            mem_addr_d     = i_arb_d_addr;
            mem_wdata_d    = i_arb_d_wdata;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            wdog_q         <= 16'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_bytectrl_q <= 3'b000;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            if_valid_q     <= 1'b0;
            d_valid_q      <= 1'b0;
            if_rdata_q     <= 32'h0;
            d_rdata_q      <= 32'h0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            wdog_q         <= wdog_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_bytectrl_q <= mem_bytectrl_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_valid_q     <= if_valid_d;
            d_valid_q      <= d_valid_d;
            if_rdata_q     <= if_rdata_d;
            d_rdata_q      <= d_rdata_d;
            err_q          <= err_d;
        end
    end

    assign o_arb_mem_req      = mem_req_q;
    assign o_arb_mem_we       = mem_we_q;
    assign o_arb_mem_bytectrl = mem_bytectrl_q;
    assign o_arb_mem_addr     = mem_addr_q;
    assign o_arb_mem_wdata    = mem_wdata_q;
    assign o_arb_if_valid     = if_valid_q;
    assign o_arb_if_rdata     = if_rdata_q;
    assign o_arb_d_valid      = d_valid_q;
    assign o_arb_d_rdata      = d_rdata_q;
    assign o_arb_err          = err_q;
    assign o_arb_stall        = (i_arb_if_req && !if_valid_q) || (i_arb_d_req && !d_valid_q);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed timing scenarios with literal expectations, then random
// requesters and bus responder checked every cycle against a transaction-level model.
module tb_rv_mem_arb;
    localparam int          TO   = 4;
    localparam logic [2:0]  WORD = 3'b010;
    localparam logic [2:0]  BYTE = 3'b000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [2:0]  d_bc;
    logic [31:0] d_addr, d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        o_if_valid, o_d_valid, o_mem_req, o_mem_we, o_stall, o_err;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [2:0]  o_mem_bc;

    int checks = 0;
    int errors = 0;

    rv_mem_arb #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_arb_if_req(if_req), .i_arb_if_addr(if_addr),
        .o_arb_if_valid(o_if_valid), .o_arb_if_rdata(o_if_rdata),
        .i_arb_d_req(d_req), .i_arb_d_we(d_we), .i_arb_d_bytectrl(d_bc),
        .i_arb_d_addr(d_addr), .i_arb_d_wdata(d_wdata),
        .o_arb_d_valid(o_d_valid), .o_arb_d_rdata(o_d_rdata),
        .o_arb_mem_req(o_mem_req), .o_arb_mem_we(o_mem_we), .o_arb_mem_bytectrl(o_mem_bc),
        .o_arb_mem_addr(o_mem_addr), .o_arb_mem_wdata(o_mem_wdata),
        .i_arb_mem_ack(mem_ack), .i_arb_mem_rdata(mem_rdata),
        .o_arb_stall(o_stall), .o_arb_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how long it has held it, and what each port must show.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_age;     // completed bus cycles of the current transaction without ack
    logic        m_last_d, m_req, m_we, m_if_valid, m_d_valid, m_err, started = 1'b0;
    logic [2:0]  m_bc;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    function automatic int pick(input logic ie, input logic de, input logic last_d);
        if (ie && de) return last_d ? 1 : 2;
        if (de) return 2;
        if (ie) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        logic acked, aborted, ie, de;
        int   win;
        started <= 1'b1;
        if (!rstn) begin
            m_owner <= 0; m_age <= 0; m_last_d <= 1'b0; m_req <= 1'b0; m_we <= 1'b0;
            m_bc <= 3'b000; m_addr <= 32'h0; m_wdata <= 32'h0; m_err <= 1'b0;
            m_if_valid <= 1'b0; m_d_valid <= 1'b0; m_if_rdata <= 32'h0; m_d_rdata <= 32'h0;
        end else begin
            acked   = (m_owner != 0) && mem_ack;
            aborted = (m_owner != 0) && !mem_ack && (m_age + 1 == TO);
            m_if_valid <= (m_owner == 1) && (acked || aborted);
            m_d_valid  <= (m_owner == 2) && (acked || aborted);
            m_err      <= aborted;
            if (m_owner == 1 && acked)            m_if_rdata <= mem_rdata;
            if (m_owner == 1 && aborted)          m_if_rdata <= 32'h0;
            if (m_owner == 2 && acked && !m_we)   m_d_rdata  <= mem_rdata;
            if (m_owner == 2 && aborted)          m_d_rdata  <= 32'h0;
            ie  = if_req && !m_if_valid && !(m_owner == 1 && (acked || aborted));
            de  = d_req && !m_d_valid && !(m_owner == 2 && (acked || aborted));
            win = (m_owner == 0 || acked) ? pick(ie, de, m_last_d) : 0;
            if (win == 1) begin
                m_owner <= 1; m_age <= 0; m_last_d <= 1'b0; m_req <= 1'b1;
                m_we <= 1'b0; m_bc <= WORD; m_addr <= if_addr; m_wdata <= 32'h0;
            end else if (win == 2) begin
                m_owner <= 2; m_age <= 0; m_last_d <= 1'b1; m_req <= 1'b1;
                m_we <= d_we; m_bc <= d_bc; m_addr <= d_addr; m_wdata <= d_wdata;
            end else if (acked || aborted) begin
                m_owner <= 0; m_req <= 1'b0;
            end else if (m_owner != 0) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("mem_req", o_mem_req, m_req);
            check("if_valid", o_if_valid, m_if_valid);
            check("d_valid", o_d_valid, m_d_valid);
            check("if_rdata", o_if_rdata, m_if_rdata);
            check("d_rdata", o_d_rdata, m_d_rdata);
            check("err", o_err, m_err);
            check("stall", o_stall, (if_req && !m_if_valid) || (d_req && !m_d_valid));
            if (m_req) begin
                check("mem_we", o_mem_we, m_we);
                check("mem_bc", o_mem_bc, m_bc);
                check("mem_addr", o_mem_addr, m_addr);
                check("mem_wdata", o_mem_wdata, m_wdata);
            end
        end
    end

    initial begin
        logic [3:0] order;
        int         n;
        rstn = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_bc = 3'b000; d_addr = 32'h0; d_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_if_valid", o_if_valid, 0);
        check("rst_d_rdata", o_d_rdata, 0);
        check("rst_err", o_err, 0);

        // Single fetch, ack in cycle 2
        #1 rstn = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        #1 check("f_stall_c0", o_stall, 1);
        @(negedge clk);
        check("f_req_c1", o_mem_req, 1);
        check("f_addr_c1", o_mem_addr, 32'h100);
        check("f_bc_c1", o_mem_bc, WORD);
        @(negedge clk);
        check("f_valid_c2", o_if_valid, 0);
        #1 mem_ack = 1'b1; mem_rdata = 32'h00000013;
        @(negedge clk);
        check("f_valid_c3", o_if_valid, 1);
        check("f_rdata_c3", o_if_rdata, 32'h00000013);
        check("f_req_c3", o_mem_req, 0);
        #1 if_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("f_valid_c4", o_if_valid, 0);

        // Concurrent fetch and byte load: D first, I back-to-back
        #1 if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_bc = BYTE; d_addr = 32'h2000;
        @(negedge clk);
        check("c_addr_d", o_mem_addr, 32'h2000);
        check("c_bc_d", o_mem_bc, BYTE);
        #1 mem_ack = 1'b1; mem_rdata = 32'h000000AB;
        @(negedge clk);
        check("c_d_valid", o_d_valid, 1);
        check("c_d_rdata", o_d_rdata, 32'h000000AB);
        check("c_req_b2b", o_mem_req, 1);
        check("c_addr_i", o_mem_addr, 32'h104);
        #1 d_req = 1'b0; mem_rdata = 32'h11111111;
        @(negedge clk);
        check("c_if_valid", o_if_valid, 1);
        check("c_if_rdata", o_if_rdata, 32'h11111111);
        check("c_d_valid_once", o_d_valid, 0);
        #1 if_req = 1'b0; mem_ack = 1'b0;

        // Both held, bus acks at once: grants must alternate D, I, D, I
        @(negedge clk);
        #1 if_req = 1'b1; if_addr = 32'h108; d_req = 1'b1; d_bc = WORD; d_addr = 32'h2004;
        mem_ack = 1'b1; mem_rdata = 32'h5;
        n = 0; order = 4'b0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (o_mem_req) begin
                order[n] = o_mem_addr[13];
                n++;
            end
        end
        check("alt_count", n, 4);
        check("alt_order", {28'h0, order}, 32'h5);
        @(negedge clk);
        #1 if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);

        // Store: fields stable until ack, load data register untouched
        #1 d_req = 1'b1; d_we = 1'b1; d_bc = WORD; d_addr = 32'h3004; d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("s_we", o_mem_we, 1);
            check("s_addr", o_mem_addr, 32'h3004);
            check("s_wdata", o_mem_wdata, 32'hDEADBEEF);
        end
        #1 mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        check("s_valid", o_d_valid, 1);
        check("s_rdata_kept", o_d_rdata, 32'h5);
        #1 d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;

        // Watchdog abort, then a stale ack while idle
        @(negedge clk);
        #1 if_req = 1'b1; if_addr = 32'h180;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("t_req_high", o_mem_req, 1);
            check("t_no_err", o_err, 0);
        end
        @(negedge clk);
        check("t_req_low", o_mem_req, 0);
        check("t_err", o_err, 1);
        check("t_valid", o_if_valid, 1);
        check("t_rdata", o_if_rdata, 0);
        #1 if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        check("t_stale_valid", o_if_valid, 0);
        check("t_stale_err", o_err, 0);
        check("t_stale_rdata", o_if_rdata, 0);
        #1 mem_ack = 1'b0;

        // Reset while the data transaction is on the bus
        @(negedge clk);
        #1 d_req = 1'b1; d_bc = 3'b001; d_addr = 32'h2100;
        @(negedge clk);
        check("r_req_before", o_mem_req, 1);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("r_req", o_mem_req, 0);
        check("r_addr", o_mem_addr, 0);
        check("r_d_valid", o_d_valid, 0);
        check("r_d_rdata", o_d_rdata, 0);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("r_regrant", o_mem_req, 1);
        check("r_regrant_addr", o_mem_addr, 32'h2100);
        #1 mem_ack = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        check("r_valid", o_d_valid, 1);
        check("r_rdata", o_d_rdata, 32'h99);
        #1 d_req = 1'b0; mem_ack = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 299) == 0) rstn = 1'b0;
            if (if_req) begin
                if (o_if_valid) begin
                    if ($urandom_range(0, 1) == 1) if_req = 1'b0;
                    else if_addr = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req) begin
                if (o_d_valid) begin
                    if ($urandom_range(0, 1) == 1) d_req = 1'b0;
                    else begin
                        d_we = 1'($urandom); d_bc = 3'($urandom); d_addr = $urandom; d_wdata = $urandom;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_bc = 3'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            mem_ack   = o_mem_req ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
        end

        @(negedge clk);
        #1 rstn = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
